// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and data load/store (D). Grants are combinational; read responses are
// steered back to the issuing master through a tag pipeline RD_LAT deep.
module imem_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int LAST = RD_LAT - 1;

  logic              rr_ptr;
  logic              if_win;
  logic              d_win;
  logic [RD_LAT-1:0] tag_vld_p;
  logic [RD_LAT-1:0] tag_id_p;
  logic [RD_LAT-1:0] tag_we_p;

  // Pick one master per cycle; rr_ptr breaks ties, reset forces no grant.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (rst_n) begin
      if (if_req_i && (!d_req_i || !rr_ptr)) begin
        if_win = 1'b1;
      end else if (d_req_i) begin
        d_win = 1'b1;
      end
    end
  end

  assign if_gnt_o = if_win;
  assign d_gnt_o  = d_win;
  assign mem_en_o = if_win | d_win;

  // Steer the granted master's request fields onto the memory port.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_win) begin
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end else if (d_win) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  // After any grant, prefer the other master next time; hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (if_win) begin
      rr_ptr <= 1'b1;
    end else if (d_win) begin
      rr_ptr <= 1'b0;
    end
  end

  // Tag pipeline: {valid, id, we} tracks each access until its data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_p <= '0;
      tag_id_p  <= '0;
      tag_we_p  <= '0;
    end else begin
      tag_vld_p[0] <= mem_en_o;
      tag_id_p[0]  <= d_win;
      tag_we_p[0]  <= d_win & d_we_i;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_id_p[i]  <= tag_id_p[i-1];
        tag_we_p[i]  <= tag_we_p[i-1];
      end
    end
  end

  // Route returning data to its owner; write acknowledges carry zero data.
  always_comb begin
    if_rvalid_o = tag_vld_p[LAST] & ~tag_id_p[LAST];
    d_rvalid_o  = tag_vld_p[LAST] & tag_id_p[LAST];
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o   = (d_rvalid_o && !tag_we_p[LAST]) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed and random-mix bench for imem_dmem_arbiter. Four instances with
// RD_LAT = 1..4 share the same master stimulus; each has its own memory model.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt    [4];
  logic        if_rvalid [4];
  logic [31:0] if_rdata  [4];
  logic        d_gnt     [4];
  logic        d_rvalid  [4];
  logic [31:0] d_rdata   [4];
  logic        mem_en    [4];
  logic        mem_we    [4];
  logic [3:0]  mem_be    [4];
  logic [31:0] mem_addr  [4];
  logic [31:0] mem_wdata [4];
  logic [31:0] mem_rdata [4];

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  logic rr_m;
  logic exp_ig;
  logic exp_dg;

  // expected responses per instance, indexed by due cycle modulo 8
  logic        ev   [4][8];
  logic        eid  [4][8];
  logic [31:0] edat [4][8];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lat
    localparam int L = g + 1;
    logic [31:0] apipe [L];

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req_i   (if_req),
      .if_addr_i  (if_addr),
      .if_gnt_o   (if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]),
      .if_rdata_o (if_rdata[g]),
      .d_req_i    (d_req),
      .d_we_i     (d_we),
      .d_be_i     (d_be),
      .d_addr_i   (d_addr),
      .d_wdata_i  (d_wdata),
      .d_gnt_o    (d_gnt[g]),
      .d_rvalid_o (d_rvalid[g]),
      .d_rdata_o  (d_rdata[g]),
      .mem_en_o   (mem_en[g]),
      .mem_we_o   (mem_we[g]),
      .mem_be_o   (mem_be[g]),
      .mem_addr_o (mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]),
      .mem_rdata_i(mem_rdata[g])
    );

    // ROM with L cycles of read latency
    always @(posedge clk) begin
      apipe[0] <= mem_addr[g];
      for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_rdata[g] = rom(apipe[L-1]);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_slots();
    for (int g = 0; g < 4; g++)
      for (int s = 0; s < 8; s++) begin
        ev[g][s]   = 1'b0;
        eid[g][s]  = 1'b0;
        edat[g][s] = 32'h0;
      end
  endtask

  // called at negedge: check grant side and due responses, then log new grant
  task automatic sb();
    int s;
    logic [65:0] rexp;
    exp_ig = rst_n && if_req && (!d_req || !rr_m);
    exp_dg = rst_n && d_req && !exp_ig;
    s = cyc % 8;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("req_L%0d_c%0d", g + 1, cyc),
          {if_gnt[g], d_gnt[g], mem_en[g], mem_we[g], mem_be[g], mem_addr[g], mem_wdata[g]},
          {exp_ig, exp_dg, exp_ig | exp_dg, exp_dg & d_we,
           exp_ig ? 4'hF : (exp_dg ? d_be : 4'h0),
           exp_ig ? if_addr : (exp_dg ? d_addr : 32'h0),
           exp_dg ? d_wdata : 32'h0});
      rexp = '0;
      if (ev[g][s]) begin
        if (eid[g][s]) rexp = {1'b0, 32'h0, 1'b1, edat[g][s]};
        else           rexp = {1'b1, edat[g][s], 1'b0, 32'h0};
      end
      chk($sformatf("rsp_L%0d_c%0d", g + 1, cyc),
          {if_rvalid[g], if_rdata[g], d_rvalid[g], d_rdata[g]}, rexp);
      ev[g][s] = 1'b0;
    end
    if (exp_ig || exp_dg) begin
      for (int g = 0; g < 4; g++) begin
        s = (cyc + g + 1) % 8;
        ev[g][s]   = 1'b1;
        eid[g][s]  = exp_dg;
        edat[g][s] = (exp_dg && d_we) ? 32'h0 : rom(exp_ig ? if_addr : d_addr);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) begin
      if (exp_ig)      rr_m = 1'b1;
      else if (exp_dg) rr_m = 1'b0;
    end
    #1;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    sb();
  endtask

  initial begin
    logic [31:0] if_seq [3];
    logic [31:0] ab_seq [4];
    rst_n = 1'b1; rr_m = 1'b0; exp_ig = 1'b0; exp_dg = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    clr_slots();
    #1 rst_n = 1'b0;

    // reset with both masters requesting: no grant, all outputs zero
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h80; d_we = 1'b1;
    d_be = 4'hF; d_wdata = 32'h1234_5678;
    repeat (3) begin
      step();
      chk("rst_outs", {if_gnt[2], d_gnt[2], mem_en[2], mem_addr[2], if_rvalid[2], d_rvalid[2]}, '0);
      adv();
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst_n = 1'b1;

    // IF only: 0x0, 0x4, 0x8 back to back
    if_seq[0] = 32'h0; if_seq[1] = 32'h4; if_seq[2] = 32'h8;
    for (int k = 0; k < 3; k++) begin
      if_req = 1'b1; if_addr = if_seq[k];
      step();
      chk("if_only_gnt", {if_gnt[2], d_gnt[2], mem_addr[2]}, {1'b1, 1'b0, if_seq[k]});
      adv();
    end
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("if_only_rsp", {if_rvalid[2], if_rdata[2], d_rvalid[2]},
          {1'b1, 32'hC0DE_0000 + 32'(4 * k), 1'b0});
      adv();
    end
    step(); adv();

    // fresh reset, then both requesting from release: IF, D, IF, D
    rst_n = 1'b0; rr_m = 1'b0; clr_slots();
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
    d_wdata = 32'h0;
    step(); adv();
    rst_n = 1'b1;
    ab_seq[0] = 32'h10; ab_seq[1] = 32'h100; ab_seq[2] = 32'h10; ab_seq[3] = 32'h100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_gnt", {if_gnt[2], d_gnt[2], mem_addr[2]},
          {(k % 2) == 0, (k % 2) == 1, ab_seq[k]});
      adv();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    chk("alt_rsp_d", {d_rvalid[2], d_rdata[2], if_rvalid[2]}, {1'b1, 32'hC0DE_0100, 1'b0});
    adv();
    step();
    chk("alt_rsp_if", {if_rvalid[2], if_rdata[2], d_rvalid[2]}, {1'b1, 32'hC0DE_0010, 1'b0});
    adv();
    repeat (3) begin step(); adv(); end

    // D write: strobes forwarded, acknowledge with zero data
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("wr_req", {d_gnt[2], mem_en[2], mem_we[2], mem_be[2], mem_addr[2], mem_wdata[2]},
        {1'b1, 1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF});
    adv();
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
    step(); adv();
    step(); adv();
    step();
    chk("wr_ack", {d_rvalid[2], d_rdata[2], if_rvalid[2]}, {1'b1, 32'h0, 1'b0});
    adv();
    step(); adv();

    // IF alone, then D alone, then conflicts go IF then D
    if_req = 1'b1; if_addr = 32'h20;
    step();
    chk("solo_if", {if_gnt[2], d_gnt[2]}, 2'b10);
    adv();
    if_req = 1'b0; d_req = 1'b1; d_be = 4'hF; d_addr = 32'h104;
    step();
    chk("solo_d", {if_gnt[2], d_gnt[2]}, 2'b01);
    adv();
    if_req = 1'b1; if_addr = 32'h24; d_addr = 32'h108;
    step();
    chk("conflict1", {if_gnt[2], d_gnt[2], mem_addr[2]}, {2'b10, 32'h24});
    adv();
    if_addr = 32'h28;
    step();
    chk("conflict2", {if_gnt[2], d_gnt[2], mem_addr[2]}, {2'b01, 32'h108});
    adv();

    // reset one cycle after two reads granted: in-flight responses dropped
    rst_n = 1'b0; rr_m = 1'b0; clr_slots();
    #1;
    chk("midrst_req", {if_gnt[2], d_gnt[2], mem_en[2], mem_we[2], mem_be[2], mem_addr[2], mem_wdata[2]}, '0);
    chk("midrst_rsp", {if_rvalid[2], if_rdata[2], d_rvalid[2], d_rdata[2]}, '0);
    step(); adv();
    if_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("midrst_quiet", {if_rvalid[2], d_rvalid[2], if_rvalid[3], d_rvalid[3]}, 4'b0000);
      adv();
    end

    // random request mix; requests held until granted
    for (int n = 0; n < 400; n++) begin
      if (!if_req || exp_ig) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = $urandom & 32'h0000_FFFC;
      end
      if (!d_req || exp_dg) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_be    = 4'($urandom_range(1, 15));
        d_addr  = $urandom & 32'h0000_FFFC;
        d_wdata = $urandom;
      end
      step(); adv();
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) begin step(); adv(); end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
